// File: rtl/frame_buffer_rw.sv
// frame_buffer_rw: single-port store for one IMG_W x IMG_H frame of DATA_W-bit pixels.
//
// A controller issues read, write, clear or no-op commands through a valid/ready command port.
// Pixels stream in through a valid/ready write port and out through a valid/ready read port.
// Either stream may stall on any beat and the address pointer is held until the beat completes.
//
// Ports:
//   clk        rising-edge clock for all logic
//   rst        synchronous, active-high reset; does not touch the pixel memory
//   cmd_valid  command present
//   cmd_op     00 read, 01 write, 10 clear, 11 no-op
//   cmd_ready  high only while idle; a command is taken on cmd_valid && cmd_ready
//   busy       high while a command is executing
//   done       one-cycle pulse in the cycle after a command completes
//   in_valid   write pixel present
//   in_data    write pixel
//   in_ready   high only while a write command runs
//   out_valid  out_data holds a frame pixel
//   out_data   registered read pixel
//   out_ready  consumer takes out_data
//   out_last   marks the beat carrying the final pixel of the frame
module frame_buffer_rw #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned DEPTH  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpNop   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StClear
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_inc;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  logic at_last;
  logic wr_fire;
  logic rd_fire;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign at_last  = (addr_q == LastAddr);
  assign wr_fire  = (state_q == StWrite) && in_valid;
  assign rd_fire  = (state_q == StRead) && out_valid_q && out_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Pixel memory has no reset; its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (cmd_valid) begin
          unique case (cmd_op)
            OpRead: begin
              // Prefetch pixel 0 so out_valid rises in the first busy cycle.
              state_d     = StRead;
              out_valid_d = 1'b1;
              out_data_d  = mem[0];
            end
            OpWrite: state_d = StWrite;
            OpClear: state_d = StClear;
            OpNop:   done_d  = 1'b1;
            default: state_d = StIdle;
          endcase
        end
      end

      StWrite: begin
        if (wr_fire) begin
          if (at_last) begin
            state_d = StIdle;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_inc;
          end
        end
      end

      StRead: begin
        if (rd_fire) begin
          if (at_last) begin
            state_d     = StIdle;
            addr_d      = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            // Load the next pixel on the accepting edge: no bubble under steady out_ready.
            addr_d     = addr_inc;
            out_data_d = mem[addr_inc];
          end
        end
      end

      StClear: begin
        if (at_last) begin
          state_d = StIdle;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_inc;
        end
      end

      default: begin
        state_d     = StIdle;
        addr_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    in_ready  = (state_q == StWrite);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_valid_q && at_last;
    done      = done_q;

    // A write coinciding with rst is dropped so an aborted command leaves memory untouched.
    mem_we    = !rst && (wr_fire || (state_q == StClear));
    mem_wdata = (state_q == StWrite) ? in_data : '0;
  end

  // Interface invariants.
  done_means_idle : assert property (@(posedge clk) disable iff (rst) done |-> cmd_ready);
  last_needs_valid : assert property (@(posedge clk) disable iff (rst) out_last |-> out_valid);
  stall_holds_data : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_frame_buffer_rw.sv
module tb_frame_buffer_rw;

  localparam int unsigned DW = 8;
  localparam int unsigned D  = 25;
  localparam int unsigned DW2 = 12;
  localparam int unsigned D2  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b11;
  logic          cmd_ready, busy, done;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic           b_cmd_valid = 1'b0;
  logic [1:0]     b_cmd_op = 2'b11;
  logic           b_cmd_ready, b_busy, b_done;
  logic           b_in_valid = 1'b0;
  logic [DW2-1:0] b_in_data = '0;
  logic           b_in_ready;
  logic           b_out_valid;
  logic [DW2-1:0] b_out_data;
  logic           b_out_ready = 1'b0;
  logic           b_out_last;

  frame_buffer_rw #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  frame_buffer_rw #(.DATA_W(DW2), .IMG_W(4), .IMG_H(3)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (b_cmd_valid),
    .cmd_op    (b_cmd_op),
    .cmd_ready (b_cmd_ready),
    .busy      (b_busy),
    .done      (b_done),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (b_out_ready),
    .out_last  (b_out_last)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame contents as the controller believes them to be.
  logic [DW-1:0] ref_mem [D];
  logic [DW-1:0] frame [D];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op);
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("cmd_ready_before_issue", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
  endtask

  // mode 0: in_valid always high; 1: 3-cycle stall after pixel 10; 2: random valid + stray cmds.
  task automatic write_frame(input int mode);
    int beats = 0;
    int cyc = 0;
    int stalls = 0;
    issue_cmd(2'b01);
    while (beats < D && cyc < 8 * D) begin
      check_eq("wr_in_ready", 32'(in_ready), 1);
      check_eq("wr_busy", 32'(busy), 1);
      case (mode)
        0: in_valid = 1'b1;
        1: begin
          if (beats == 10 && stalls < 3) begin
            in_valid = 1'b0;
            stalls++;
          end else begin
            in_valid = 1'b1;
          end
        end
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = in_valid ? frame[beats] : DW'($urandom);
      if (mode == 2 && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
      end
      step();
      cmd_valid = 1'b0;
      if (in_valid) begin
        ref_mem[beats] = frame[beats];
        beats++;
      end
      in_valid = 1'b0;
      cyc++;
    end
    check_eq("wr_beats", beats, D);
    if (mode == 0) check_eq("wr_cycles", cyc, D);
    if (mode == 1) check_eq("wr_stall_cycles", cyc, D + 3);
    check_eq("wr_done", 32'(done), 1);
    check_eq("wr_in_ready_after", 32'(in_ready), 0);
    check_eq("wr_cmd_ready_after", 32'(cmd_ready), 1);
  endtask

  // mode 0: out_ready high; 1: pattern 1,0,0; 2: random. abort_at >= 0 resets on that pixel.
  task automatic read_frame(input int mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int phase = 0;
    issue_cmd(2'b00);
    while (idx < D && cyc < 8 * D) begin
      check_eq("rd_valid", 32'(out_valid), 1);
      check_eq("rd_data", 32'(out_data), 32'(ref_mem[idx]));
      check_eq("rd_last", 32'(out_last), 32'(idx == D - 1));
      check_eq("rd_in_ready", 32'(in_ready), 0);
      if (idx == abort_at) begin
        rst = 1'b1;
        step();
        check_eq("abort_out_valid", 32'(out_valid), 0);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 1);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_busy", 32'(busy), 0);
        rst = 1'b0;
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (phase % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      // Stray write-port traffic must not land in memory during a read.
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      step();
      if (out_ready) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("rd_beats", idx, D);
    if (mode == 0) check_eq("rd_cycles", cyc, D);
    check_eq("rd_done", 32'(done), 1);
    check_eq("rd_valid_after", 32'(out_valid), 0);
    check_eq("rd_cmd_ready_after", 32'(cmd_ready), 1);
  endtask

  task automatic clear_frame();
    int cyc = 0;
    issue_cmd(2'b10);
    while (busy === 1'b1 && cyc < 8 * D) begin
      cyc++;
      step();
    end
    check_eq("clr_busy_cycles", cyc, D);
    check_eq("clr_done", 32'(done), 1);
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
  endtask

  task automatic small_write_read();
    logic [DW2-1:0] f2 [D2];
    for (int i = 0; i < D2; i++) f2[i] = DW2'($urandom);
    b_cmd_valid = 1'b1;
    b_cmd_op    = 2'b01;
    step();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < D2; i++) begin
      check_eq("s_wr_in_ready", 32'(b_in_ready), 1);
      b_in_valid = 1'b1;
      b_in_data  = f2[i];
      step();
    end
    b_in_valid = 1'b0;
    check_eq("s_wr_done", 32'(b_done), 1);
    check_eq("s_wr_busy_after", 32'(b_busy), 0);
    b_cmd_valid = 1'b1;
    b_cmd_op    = 2'b00;
    step();
    b_cmd_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < D2; i++) begin
      check_eq("s_rd_valid", 32'(b_out_valid), 1);
      check_eq("s_rd_data", 32'(b_out_data), 32'(f2[i]));
      check_eq("s_rd_last", 32'(b_out_last), 32'(i == D2 - 1));
      step();
    end
    b_out_ready = 1'b0;
    check_eq("s_rd_done", 32'(b_done), 1);
    check_eq("s_rd_valid_after", 32'(b_out_valid), 0);
    check_eq("s_cmd_ready_after", 32'(b_cmd_ready), 1);
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    rst = 1'b0;
    step();

    // Write 1..25 then read it back, issuing the read in the write's done cycle.
    for (int i = 0; i < D; i++) frame[i] = DW'(i + 1);
    write_frame(0);
    read_frame(0, -1);

    // No-op: done in T+1 without ever going busy.
    issue_cmd(2'b11);
    check_eq("nop_done", 32'(done), 1);
    check_eq("nop_busy", 32'(busy), 0);
    check_eq("nop_cmd_ready", 32'(cmd_ready), 1);
    step();
    check_eq("nop_done_pulse", 32'(done), 0);

    // Write stall, read backpressure.
    for (int i = 0; i < D; i++) frame[i] = DW'(i + 1);
    write_frame(1);
    read_frame(1, -1);

    // Clear then read zeros.
    clear_frame();
    read_frame(0, -1);

    // Reset mid-read on pixel 12; memory survives.
    write_frame(0);
    read_frame(0, 11);
    step();
    read_frame(0, -1);

    // Random frames with stalls, stray commands and random backpressure.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < D; i++) frame[i] = DW'($urandom);
      write_frame(2);
      read_frame(2, -1);
    end

    // 4x3 frame of 12-bit pixels.
    small_write_read();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_rw.md
# frame_buffer_rw

Parametrised single-port frame store between the grayscaling stage and downstream consumers; next generation of the 5x5 RWM store. Holds one IMG_W x IMG_H frame of DATA_W-bit pixels. Executes read, write and clear commands issued by the controller. Valid/ready handshakes on the pixel input and output let either side stall at any beat without losing the address pointer.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 5, frame width in pixels
- IMG_H, 5, frame height in pixels
- DEPTH (localparam), IMG_W*IMG_H, number of stored pixels
- ADDR_W (localparam), $clog2(DEPTH) (min 1), address pointer width

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  controller presents a command
- cmd_op  in  2  00 read, 01 write, 10 clear, 11 no-op
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion of every accepted command
- in_valid  in  1  grayscaler presents in_data
- in_data  in  DATA_W  pixel to write
- in_ready  out  1  high only in WRITE
- out_valid  out  1  out_data holds a frame pixel
- out_data  out  DATA_W  pixel read; driven, never tristated
- out_ready  in  1  consumer accepts out_data
- out_last  out  1  high with out_valid on the beat for address DEPTH-1

## Operation
- States: IDLE, WRITE, READ, CLEAR. Internal addr pointer (ADDR_W bits) and the DEPTH x DATA_W memory array.
- IDLE: addr=0, cmd_ready=1. On acceptance, op 00 -> READ, 01 -> WRITE, 10 -> CLEAR, 11 -> stays IDLE and pulses done next cycle.
- WRITE: every in_valid && in_ready beat writes mem[addr]<=in_data and increments addr. When in_valid is low, hold addr and memory unchanged (replaces the old WAIT state; no state change). The beat at addr=DEPTH-1 -> IDLE, addr=0.
- READ: pixels are streamed in address order 0..DEPTH-1. A beat completes on out_valid && out_ready. While out_valid && !out_ready, out_data, out_last and the internal address stay stable. After the DEPTH-1 beat -> IDLE, out_valid low.
- CLEAR: one word per cycle, mem[addr]<=0, addr increments without a handshake. After addr=DEPTH-1 -> IDLE.
- cmd_valid outside IDLE is ignored; no command queueing.
- Input and output ports are independent: in_valid during READ/CLEAR/IDLE is ignored (no write). out_ready outside READ is ignored.
- rst at any time, including mid-command: state IDLE, addr 0, out_valid 0, done 0. Memory contents are not cleared by rst; they are undefined only after power-up.

## Timing
- Reset values: cmd_ready 1, busy 0, done 0, in_ready 0, out_valid 0, out_data 0, out_last 0.
- Command accepted at edge T -> busy and the mode-specific ready/valid go high from T+1.
- WRITE: in_ready is high from T+1 until the edge that accepts the last beat. It is low in the following cycle. The memory write commits at the accepting edge.
- Minimum durations with no stalls: WRITE is DEPTH cycles; CLEAR is DEPTH cycles.
- READ latency: out_valid is first high in cycle T+1 with mem[0]. With out_ready held high, one pixel per cycle, so DEPTH cycles total. out_data is registered, and the block must not insert bubbles under continuous out_ready.
- done is high exactly one cycle, in the cycle after the final beat/word, coincident with cmd_ready returning to 1. For no-op, done is high in T+1.
- A new command may be accepted in the same cycle done is high.
- A read issued directly after a write or clear returns the new data; there is no read-after-write hazard at the frame boundary.

## Test plan
- Write then read: reset, cmd write, stream 1..25 with in_valid always high, then cmd read with out_ready high. Required: done at write end; out_data 1..25 on consecutive cycles; out_last only on 25; done one cycle after.
- Write stall: during write, drop in_valid for 3 cycles after pixel 10. Required: in_ready stays high, no writes occur, addr holds; readback gives 1..25 exactly.
- Read backpressure: read with out_ready toggled 1,0,0,1,... Required: out_data stable during stalls; sequence 1..25 with no loss or duplication; out_last on 25.
- Clear: after a write, cmd clear. Required: busy high for 25 cycles, then done; readback gives 25 zeros.
- Reset mid-read: assert rst at pixel 12 of a read. Required: next cycle out_valid 0, cmd_ready 1, done 0; a new read returns the original 1..25 (memory preserved).
- Ignored/no-op commands: cmd_valid during a write, plus op 11 in IDLE. Required: the write is unaffected; no-op gives done in T+1 with busy never high; params IMG_W=4, IMG_H=3, DATA_W=12 pass the write-then-read case with 12 beats.
